// File: rtl/alu_operand_stage.sv
// ID/EX operand stage: latches one decoded instruction, forwards operands
// (EX/MEM > MEM/WB > latched), holds the carry flag and drives the ALU inputs.
module alu_operand_stage #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned RADDR_W = 2,
    parameter logic [3:0]  OP_ADD  = 4'h1,
    parameter logic [3:0]  OP_SUB  = 4'h2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               id_valid,
    output logic               id_ready,
    input  logic [3:0]         id_op,
    input  logic [RADDR_W-1:0] id_rs_addr,
    input  logic [RADDR_W-1:0] id_rt_addr,
    input  logic [WIDTH-1:0]   id_rs_data,
    input  logic [WIDTH-1:0]   id_rt_data,
    input  logic [WIDTH-1:0]   id_imm,
    input  logic               id_use_imm,
    input  logic               id_use_carry,
    input  logic [RADDR_W-1:0] id_rd_addr,
    input  logic               id_reg_write,
    input  logic               id_is_load,
    input  logic               mem_fwd_en,
    input  logic [RADDR_W-1:0] mem_fwd_addr,
    input  logic [WIDTH-1:0]   mem_fwd_data,
    input  logic               mem_is_load,
    input  logic               wb_fwd_en,
    input  logic [RADDR_W-1:0] wb_fwd_addr,
    input  logic [WIDTH-1:0]   wb_fwd_data,
    output logic               ex_valid,
    input  logic               ex_ready,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic               alu_cin,
    output logic [3:0]         alu_op,
    input  logic               alu_cout,
    output logic [RADDR_W-1:0] ex_rd_addr,
    output logic               ex_reg_write,
    output logic               ex_is_load
);

    logic               r_full;
    logic               r_carry;
    logic [3:0]         r_op;
    logic [RADDR_W-1:0] r_rs_addr;
    logic [RADDR_W-1:0] r_rt_addr;
    logic [WIDTH-1:0]   r_rs_data;
    logic [WIDTH-1:0]   r_rt_data;
    logic [WIDTH-1:0]   r_imm;
    logic               r_use_imm;
    logic               r_use_carry;
    logic [RADDR_W-1:0] r_rd_addr;
    logic               r_reg_write;
    logic               r_is_load;

    logic w_rs_mem_hit;
    logic w_rt_mem_hit;
    logic w_rs_wb_hit;
    logic w_rt_wb_hit;
    logic w_hazard;
    logic w_accept;
    logic w_drain;

    assign w_rs_mem_hit = mem_fwd_en & (mem_fwd_addr == r_rs_addr);
    assign w_rt_mem_hit = mem_fwd_en & (mem_fwd_addr == r_rt_addr);
    assign w_rs_wb_hit  = wb_fwd_en & (wb_fwd_addr == r_rs_addr);
    assign w_rt_wb_hit  = wb_fwd_en & (wb_fwd_addr == r_rt_addr);

    // A load still in EX/MEM has no data yet; hold until it reaches MEM/WB.
    assign w_hazard = r_full & mem_fwd_en & mem_is_load &
                      (w_rs_mem_hit | (w_rt_mem_hit & ~r_use_imm));

    // Reset gating keeps any handshake from completing in the reset cycle.
    assign ex_valid = r_full & ~w_hazard & ~flush & ~reset;
    assign id_ready = ~r_full | (ex_valid & ex_ready);
    assign w_drain  = ex_valid & ex_ready;
    assign w_accept = id_valid & id_ready & ~flush & ~reset;

    // Operand selection, re-evaluated every cycle so held operands stay current.
    always_comb begin
        alu_a = r_rs_data;
        alu_b = r_rt_data;
        if (w_rs_mem_hit) begin
            alu_a = mem_fwd_data;
        end else if (w_rs_wb_hit) begin
            alu_a = wb_fwd_data;
        end
        if (r_use_imm) begin
            alu_b = r_imm;
        end else if (w_rt_mem_hit) begin
            alu_b = mem_fwd_data;
        end else if (w_rt_wb_hit) begin
            alu_b = wb_fwd_data;
        end
    end

    assign alu_cin      = r_use_carry & r_carry;
    assign alu_op       = r_op;
    assign ex_rd_addr   = r_rd_addr;
    assign ex_reg_write = r_reg_write;
    assign ex_is_load   = r_is_load;

    // Instruction latch and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_full      <= 1'b0;
            r_op        <= 4'h0;
            r_rs_addr   <= '0;
            r_rt_addr   <= '0;
            r_rs_data   <= '0;
            r_rt_data   <= '0;
            r_imm       <= '0;
            r_use_imm   <= 1'b0;
            r_use_carry <= 1'b0;
            r_rd_addr   <= '0;
            r_reg_write <= 1'b0;
            r_is_load   <= 1'b0;
        end else if (flush) begin
            r_full <= 1'b0;
        end else if (w_accept) begin
            r_full      <= 1'b1;
            r_op        <= id_op;
            r_rs_addr   <= id_rs_addr;
            r_rt_addr   <= id_rt_addr;
            r_rs_data   <= id_rs_data;
            r_rt_data   <= id_rt_data;
            r_imm       <= id_imm;
            r_use_imm   <= id_use_imm;
            r_use_carry <= id_use_carry;
            r_rd_addr   <= id_rd_addr;
            r_reg_write <= id_reg_write;
            r_is_load   <= id_is_load;
        end else if (w_drain) begin
            r_full <= 1'b0;
        end
    end

    // Carry flag updates only when an ADD/SUB actually transfers to EX.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_carry <= 1'b0;
        end else if (w_drain && (r_op == OP_ADD || r_op == OP_SUB)) begin
            r_carry <= alu_cout;
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: handshake, forwarding priority,
// load-use stall, carry chaining, back-pressure, flush and reset.
module tb_alu_operand_stage;

    localparam int unsigned WIDTH   = 16;
    localparam int unsigned RADDR_W = 2;
    localparam logic [3:0]  OP_ADD  = 4'h1;
    localparam logic [3:0]  OP_SUB  = 4'h2;
    localparam logic [3:0]  OP_ADC  = 4'h3;
    localparam logic [3:0]  OP_AND  = 4'h4;

    logic               clk = 1'b0;
    logic               reset, flush, id_valid, id_ready;
    logic [3:0]         id_op;
    logic [RADDR_W-1:0] id_rs_addr, id_rt_addr, id_rd_addr;
    logic [WIDTH-1:0]   id_rs_data, id_rt_data, id_imm;
    logic               id_use_imm, id_use_carry, id_reg_write, id_is_load;
    logic               mem_fwd_en, mem_is_load, wb_fwd_en;
    logic [RADDR_W-1:0] mem_fwd_addr, wb_fwd_addr;
    logic [WIDTH-1:0]   mem_fwd_data, wb_fwd_data;
    logic               ex_valid, ex_ready, alu_cin, alu_cout;
    logic [WIDTH-1:0]   alu_a, alu_b;
    logic [3:0]         alu_op;
    logic [RADDR_W-1:0] ex_rd_addr;
    logic               ex_reg_write, ex_is_load;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_operand_stage #(.WIDTH(WIDTH), .RADDR_W(RADDR_W), .OP_ADD(OP_ADD), .OP_SUB(OP_SUB)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready), .id_op(id_op),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_use_imm(id_use_imm), .id_use_carry(id_use_carry),
        .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
        .mem_fwd_en(mem_fwd_en), .mem_fwd_addr(mem_fwd_addr), .mem_fwd_data(mem_fwd_data),
        .mem_is_load(mem_is_load),
        .wb_fwd_en(wb_fwd_en), .wb_fwd_addr(wb_fwd_addr), .wb_fwd_data(wb_fwd_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_op(alu_op), .alu_cout(alu_cout),
        .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change afterwards, checks follow a settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic offer(input logic [3:0] op, input logic [1:0] rs, input logic [15:0] rsd,
                         input logic [1:0] rt, input logic [15:0] rtd, input logic use_carry);
        id_valid = 1'b1; id_op = op;
        id_rs_addr = rs; id_rs_data = rsd;
        id_rt_addr = rt; id_rt_data = rtd;
        id_use_carry = use_carry; id_use_imm = 1'b0; id_imm = '0;
        id_rd_addr = 2'd3; id_reg_write = 1'b1; id_is_load = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; id_valid = 1'b0; id_op = '0;
        id_rs_addr = '0; id_rt_addr = '0; id_rd_addr = '0;
        id_rs_data = '0; id_rt_data = '0; id_imm = '0;
        id_use_imm = 1'b0; id_use_carry = 1'b0; id_reg_write = 1'b0; id_is_load = 1'b0;
        mem_fwd_en = 1'b0; mem_fwd_addr = '0; mem_fwd_data = '0; mem_is_load = 1'b0;
        wb_fwd_en = 1'b0; wb_fwd_addr = '0; wb_fwd_data = '0;
        ex_ready = 1'b1; alu_cout = 1'b0;

        // Reset with an offer pending: nothing may be latched.
        #1;
        offer(OP_SUB, 2'd1, 16'h1111, 2'd2, 16'h2222, 1'b1);
        tick(); tick();
        reset = 1'b0; id_valid = 1'b0;
        settle();
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_id_ready", 32'(id_ready), 32'd1);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_b", 32'(alu_b), 32'd0);
        chk("rst_alu_cin", 32'(alu_cin), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_ex_rd", 32'(ex_rd_addr), 32'd0);
        chk("rst_ex_wr", 32'(ex_reg_write), 32'd0);

        // 1. ADD r1(5), r2(7), one cycle ID->EX.
        offer(OP_ADD, 2'd1, 16'd5, 2'd2, 16'd7, 1'b0);
        settle();
        chk("t1_id_ready", 32'(id_ready), 32'd1);
        tick();
        id_valid = 1'b0;
        settle();
        chk("t1_ex_valid", 32'(ex_valid), 32'd1);
        chk("t1_alu_a", 32'(alu_a), 32'd5);
        chk("t1_alu_b", 32'(alu_b), 32'd7);
        chk("t1_alu_cin", 32'(alu_cin), 32'd0);
        chk("t1_alu_op", 32'(alu_op), 32'(OP_ADD));
        chk("t1_ex_rd", 32'(ex_rd_addr), 32'd3);
        chk("t1_ex_wr", 32'(ex_reg_write), 32'd1);

        // 2. Accept AND while ADD drains, then hold and probe forwarding priority.
        offer(OP_AND, 2'd1, 16'd5, 2'd2, 16'd7, 1'b0);
        settle();
        chk("t2_replace_ready", 32'(id_ready), 32'd1);
        tick();
        id_valid = 1'b0; ex_ready = 1'b0;
        mem_fwd_en = 1'b1; mem_fwd_addr = 2'd1; mem_fwd_data = 16'h0010;
        wb_fwd_en = 1'b1; wb_fwd_addr = 2'd1; wb_fwd_data = 16'h0020;
        settle();
        chk("t2_mem_prio", 32'(alu_a), 32'h0010);
        chk("t2_b_latched", 32'(alu_b), 32'd7);
        chk("t2_held_ready", 32'(id_ready), 32'd0);
        mem_fwd_en = 1'b0;
        settle();
        chk("t2_wb_fwd", 32'(alu_a), 32'h0020);
        wb_fwd_en = 1'b0;
        settle();
        chk("t2_latched", 32'(alu_a), 32'd5);

        // 3. Load-use stall on rt, released when the load forwards from MEM/WB.
        ex_ready = 1'b1;
        mem_fwd_en = 1'b1; mem_fwd_addr = 2'd2; mem_fwd_data = 16'hDEAD; mem_is_load = 1'b1;
        settle();
        chk("t3_stall_valid", 32'(ex_valid), 32'd0);
        chk("t3_stall_ready", 32'(id_ready), 32'd0);
        tick();
        mem_fwd_en = 1'b0; mem_is_load = 1'b0;
        wb_fwd_en = 1'b1; wb_fwd_addr = 2'd2; wb_fwd_data = 16'h1234;
        settle();
        chk("t3_release_valid", 32'(ex_valid), 32'd1);
        chk("t3_release_b", 32'(alu_b), 32'h1234);
        tick();
        wb_fwd_en = 1'b0;
        settle();
        chk("t3_drained", 32'(ex_valid), 32'd0);
        chk("t3_empty_ready", 32'(id_ready), 32'd1);

        // Immediate B: no forwarding on B and no load-use stall through rt.
        offer(OP_AND, 2'd1, 16'd9, 2'd2, 16'd7, 1'b0);
        id_use_imm = 1'b1; id_imm = 16'h00AB;
        tick();
        id_valid = 1'b0; id_use_imm = 1'b0; ex_ready = 1'b0;
        mem_fwd_en = 1'b1; mem_fwd_addr = 2'd2; mem_fwd_data = 16'hBEEF; mem_is_load = 1'b1;
        settle();
        chk("imm_no_stall", 32'(ex_valid), 32'd1);
        chk("imm_b", 32'(alu_b), 32'h00AB);
        mem_fwd_en = 1'b0; mem_is_load = 1'b0; ex_ready = 1'b1;
        tick();

        // 4. ADD 0xFFFF+1 sets carry; ADC queued behind it sees cin=1.
        offer(OP_ADD, 2'd1, 16'hFFFF, 2'd2, 16'h0001, 1'b0);
        tick();
        alu_cout = 1'b1;
        offer(OP_ADC, 2'd1, 16'h0000, 2'd2, 16'h0000, 1'b1);
        settle();
        chk("t4_add_valid", 32'(ex_valid), 32'd1);
        chk("t4_add_a", 32'(alu_a), 32'hFFFF);
        tick();
        alu_cout = 1'b0; id_valid = 1'b0;
        settle();
        chk("t4_adc_op", 32'(alu_op), 32'(OP_ADC));
        chk("t4_adc_cin", 32'(alu_cin), 32'd1);
        chk("t4_adc_valid", 32'(ex_valid), 32'd1);

        // 5. Back-pressure for 3 cycles, then one transfer with a queued instruction.
        ex_ready = 1'b0;
        offer(OP_AND, 2'd0, 16'h0AAA, 2'd3, 16'h0BBB, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_hold_valid", 32'(ex_valid), 32'd1);
            chk("t5_hold_op", 32'(alu_op), 32'(OP_ADC));
            chk("t5_hold_a", 32'(alu_a), 32'd0);
            chk("t5_hold_cin", 32'(alu_cin), 32'd1);
            chk("t5_hold_ready", 32'(id_ready), 32'd0);
        end
        ex_ready = 1'b1;
        settle();
        chk("t5_release_ready", 32'(id_ready), 32'd1);
        tick();
        id_valid = 1'b0; ex_ready = 1'b0;
        settle();
        chk("t5_no_bubble", 32'(ex_valid), 32'd1);
        chk("t5_next_op", 32'(alu_op), 32'(OP_AND));
        chk("t5_next_a", 32'(alu_a), 32'h0AAA);
        chk("t5_next_b", 32'(alu_b), 32'h0BBB);

        // 6. Flush while full ignores id_valid and keeps carry.
        flush = 1'b1; ex_ready = 1'b1;
        offer(OP_SUB, 2'd1, 16'h0001, 2'd2, 16'h0002, 1'b0);
        settle();
        chk("t6_flush_valid", 32'(ex_valid), 32'd0);
        tick();
        flush = 1'b0; id_valid = 1'b0;
        settle();
        chk("t6_post_flush_valid", 32'(ex_valid), 32'd0);
        chk("t6_post_flush_ready", 32'(id_ready), 32'd1);
        offer(OP_ADC, 2'd1, 16'h0000, 2'd2, 16'h0000, 1'b1);
        ex_ready = 1'b0;
        tick();
        id_valid = 1'b0;
        settle();
        chk("t6_carry_kept", 32'(alu_cin), 32'd1);
        chk("t6_adc_valid", 32'(ex_valid), 32'd1);

        // Reset while full discards the instruction and clears carry.
        reset = 1'b1;
        settle();
        chk("t6_rst_cycle_valid", 32'(ex_valid), 32'd0);
        tick();
        reset = 1'b0;
        settle();
        chk("t6_rst_valid", 32'(ex_valid), 32'd0);
        chk("t6_rst_ready", 32'(id_ready), 32'd1);
        offer(OP_ADC, 2'd1, 16'h0000, 2'd2, 16'h0000, 1'b1);
        tick();
        id_valid = 1'b0;
        settle();
        chk("t6_carry_cleared", 32'(alu_cin), 32'd0);
        chk("t6_adc2_valid", 32'(ex_valid), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
